upg_mem_arbiter: RTL



---
 rtl/upg_arb_pkg.sv | 18 +
 rtl/upg_mem_arbiter_edge_detect.sv | 28 ++
 rtl/upg_mem_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/upg_arb_pkg.sv
// Shared types and defaults for the UART-programmer / CPU memory arbiter.
//   arb_state_e  : ownership state, also exported as the mode display code
//   ADR_W_DEF    : default word address width of each memory
//   DAT_W_DEF    : default data width
//   DMEM_SEL_BIT : bit of the programmer address that selects dmem over imem
package upg_arb_pkg;

    localparam int unsigned ADR_W_DEF    = 14;
    localparam int unsigned DAT_W_DEF    = 32;
    localparam int unsigned DMEM_SEL_BIT = ADR_W_DEF;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } arb_state_e;

endpackage

// File: rtl/upg_mem_arbiter_edge_detect.sv
// Rising-edge detector: compares the input against its registered copy.
//   clk, rst : clock, synchronous active-high reset
//   din      : level input
//   rise_c   : high in the first cycle din is seen high after being low
module upg_mem_arbiter_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise_c
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = din;
        rise_c = din & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/upg_mem_arbiter.sv
// Memory port arbiter between the UART programmer and the CPU load/store path.
// After reset the programmer owns imem/dmem (BOOT) with the CPU held; upg_done
// hands ownership to the CPU (RUN); a upg_start edge drains any CPU access and
// returns to BOOT.
//   cpu_*  : CPU dmem request/ack handshake, cpu_hold keeps the CPU in reset
//   upg_*  : programmer write port, done/start levels, upg_rst holds it in reset
//   imem_* : instruction memory write port
//   dmem_* : data memory port, dmem_rdat has one cycle of BRAM latency
//   prog_cnt : words written in the current BOOT session
//   mode   : current state code for display
module upg_mem_arbiter
    import upg_arb_pkg::*;
#(
    parameter int unsigned ADR_W     = ADR_W_DEF,
    parameter int unsigned DAT_W     = DAT_W_DEF,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DRAIN_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [ADR_W-1:0] cpu_adr,
    input  logic [DAT_W-1:0] cpu_wdat,
    output logic [DAT_W-1:0] cpu_rdat,
    output logic             cpu_ack,
    output logic             cpu_hold,
    input  logic             upg_wen,
    input  logic [ADR_W:0]   upg_adr,
    input  logic [DAT_W-1:0] upg_dat,
    input  logic             upg_done,
    input  logic             upg_start,
    output logic             upg_rst,
    output logic             imem_wen,
    output logic [ADR_W-1:0] imem_adr,
    output logic [DAT_W-1:0] imem_dat,
    output logic             dmem_wen,
    output logic [ADR_W-1:0] dmem_adr,
    output logic [DAT_W-1:0] dmem_dat,
    input  logic [DAT_W-1:0] dmem_rdat,
    output logic [CNT_W-1:0] prog_cnt,
    output logic [1:0]       mode
);

    localparam int unsigned DC_W = (DRAIN_MAX > 2) ? $clog2(DRAIN_MAX) : 1;

    arb_state_e       state_q, state_d;
    logic             outst_q, outst_d;
    logic             ack_q, ack_d;
    logic [DAT_W-1:0] rdat_q, rdat_d;
    logic [CNT_W-1:0] prog_cnt_q, prog_cnt_d;
    logic [DC_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic             hold_q, hold_d;
    logic             upg_rst_q, upg_rst_d;
    logic             grant;
    logic             start_rise;

    upg_mem_arbiter_edge_detect u_start_edge (
        .clk    (clk),
        .rst    (rst),
        .din    (upg_start),
        .rise_c (start_rise)
    );

    // Next state, memory port mux and counters
    always_comb begin
        state_d     = state_q;
        prog_cnt_d  = prog_cnt_q;
        drain_cnt_d = '0;
        rdat_d      = rdat_q;
        grant       = 1'b0;
        imem_wen    = 1'b0;
        imem_adr    = '0;
        imem_dat    = '0;
        dmem_wen    = 1'b0;
        dmem_adr    = '0;
        dmem_dat    = '0;

        unique case (state_q)
            ST_BOOT: begin
                imem_wen = upg_wen & ~upg_adr[ADR_W];
                imem_adr = upg_adr[ADR_W-1:0];
                imem_dat = upg_dat;
                dmem_wen = upg_wen & upg_adr[ADR_W];
                dmem_adr = upg_adr[ADR_W-1:0];
                dmem_dat = upg_dat;
                if (upg_wen && (prog_cnt_q != '1)) begin
                    prog_cnt_d = prog_cnt_q + CNT_W'(1);
                end
                if (upg_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // At most one access in flight, so a held request is granted every other cycle
                if (cpu_req && !outst_q) begin
                    grant    = 1'b1;
                    dmem_wen = cpu_we;
                    dmem_adr = cpu_adr;
                    dmem_dat = cpu_wdat;
                end
                if (start_rise) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Timeout guards against an access that never retires
                if (!outst_q || (drain_cnt_q == DC_W'(DRAIN_MAX - 1))) begin
                    state_d    = ST_BOOT;
                    prog_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + DC_W'(1);
                end
            end
            default: begin
                state_d    = ST_BOOT;
                prog_cnt_d = '0;
            end
        endcase

        outst_d = grant;
        ack_d   = grant;
        if (ack_q) begin
            rdat_d = dmem_rdat;
        end

        hold_d    = (state_d == ST_BOOT);
        upg_rst_d = (state_d != ST_BOOT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            outst_q     <= 1'b0;
            ack_q       <= 1'b0;
            rdat_q      <= '0;
            prog_cnt_q  <= '0;
            drain_cnt_q <= '0;
            hold_q      <= 1'b1;
            upg_rst_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            outst_q     <= outst_d;
            ack_q       <= ack_d;
            rdat_q      <= rdat_d;
            prog_cnt_q  <= prog_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            hold_q      <= hold_d;
            upg_rst_q   <= upg_rst_d;
        end
    end

    // BRAM data arrives in the ack cycle; pass it through then, hold it afterwards
    always_comb begin
        cpu_rdat = ack_q ? dmem_rdat : rdat_q;
        cpu_ack  = ack_q;
        cpu_hold = hold_q;
        upg_rst  = upg_rst_q;
        prog_cnt = prog_cnt_q;
        mode     = state_q;
    end

endmodule
